// File: rtl/reflet_muldiv_seq.sv
// Iterative multiply/divide sequencer for the reflet core: shift-add multiply and
// restoring divide, one bit per clock, with a start/busy/done handshake.
module reflet_muldiv_seq #(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [wordsize-1:0] working_register,
    input  logic [wordsize-1:0] other_register,
    output logic                busy,
    output logic                done,
    output logic [wordsize-1:0] out,
    output logic [3:0]          out_reg,
    output logic                div0
);

    localparam int W  = wordsize;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    out_q, out_d;
    logic            div0_q, div0_d;

    logic [W:0]      mul_sum;
    logic [2*W-1:0]  prod_step;
    logic [W:0]      rem_trial;
    logic            fits;
    logic [W-1:0]    rem_step;
    logic [W-1:0]    quo_step;
    logic [W-1:0]    result;

    // One iteration of each algorithm; the RUN state commits whichever op_q selects.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : '0);
        prod_step = {mul_sum, prod_q[W-1:1]};
        // The trial remainder needs W+1 bits; once B is subtracted it fits back in W.
        rem_trial = {rem_q, quo_q[W-1]};
        fits      = (rem_trial >= {1'b0, b_q});
        rem_step  = fits ? W'(rem_trial - {1'b0, b_q}) : rem_trial[W-1:0];
        quo_step  = {quo_q[W-2:0], fits};
        unique case (op_q)
            2'd0:    result = prod_step[W-1:0];
            2'd1:    result = prod_step[2*W-1:W];
            2'd2:    result = quo_step;
            default: result = rem_step;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a signal unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        out_d   = out_q;
        div0_d  = div0_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d    = working_register;
                    b_d    = other_register;
                    op_d   = op;
                    cnt_d  = CW'(W);
                    div0_d = 1'b0;
                    prod_d = {{W{1'b0}}, other_register};
                    rem_d  = '0;
                    quo_d  = working_register;
                    if (op[1] && (other_register == '0)) begin
                        // Divide by zero skips RUN: quotient saturates, remainder is the dividend.
                        state_d = S_DONE;
                        div0_d  = 1'b1;
                        out_d   = op[0] ? working_register : '1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q[1]) begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                end else begin
                    prod_d = prod_step;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    out_d   = result;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            out_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            out_q   <= out_d;
            div0_q  <= div0_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign out     = out_q;
    assign div0    = div0_q;
    assign out_reg = 4'h0;

endmodule
